// File: rtl/tlk_tx_align_if.sv
// Payload handshake between the LV2 event formatter (master) and the TLK TX aligner (slave).
interface tlk_tx_align_if #(
    parameter int DW = 16
) ();
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/tlk_tx_align.sv
// TLK transmit link bring-up: error-propagation training burst, IDLE hold, then data pass-through.
// Optional retrain_cnt statistics output is built only when TLKTX_STATS_EN is defined.
module tlk_tx_align #(
    parameter int DW           = 16,
    parameter int TRAIN_CYCLES = 1024,
    parameter int HOLD_CYCLES  = 512,
    parameter int TW           = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          LIVE,
    input  logic          retrain,
    tlk_tx_align_if.slave in_if,
    output logic [DW-1:0] tx_data,
    output logic          tx_en,
    output logic          tx_er,
    output logic          link_up
`ifdef TLKTX_STATS_EN
    ,
    output logic [15:0]   retrain_cnt
`endif
);

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_TRAIN  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          tx_en_q, tx_en_d;
    logic          tx_er_q, tx_er_d;
    logic          link_up_q, link_up_d;
    logic          xfer;

    // Ready is combinational so a LIVE drop or retrain blocks the transfer in the same cycle.
    assign in_if.in_ready = (state_q == ST_RUN) & LIVE & ~retrain;
    assign xfer           = in_if.in_valid & in_if.in_ready;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!LIVE) begin
            state_d = ST_OFF;
            timer_d = '0;
        end else if (retrain) begin
            state_d = ST_TRAIN;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_TRAIN;
                    timer_d = '0;
                end
                ST_TRAIN: begin
                    if (timer_q == TRAIN_LAST) begin
                        state_d = ST_SETTLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (timer_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_RUN:  state_d = ST_RUN;
                default: begin
                    state_d = ST_OFF;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Pin encoding follows the next state, so the first TRAIN word appears right after the LIVE edge.
    always_comb begin
        tx_data_d = '0;
        tx_en_d   = 1'b0;
        tx_er_d   = 1'b0;
        link_up_d = (state_d == ST_RUN);
        if (state_d == ST_TRAIN) begin
            tx_data_d = '1;
            tx_en_d   = 1'b1;
            tx_er_d   = 1'b1;
        end else if (xfer) begin
            tx_data_d = in_if.in_data;
            tx_en_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_OFF;
            timer_q   <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            link_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            tx_er_q   <= tx_er_d;
            link_up_q <= link_up_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_en   = tx_en_q;
    assign tx_er   = tx_er_q;
    assign link_up = link_up_q;

`ifdef TLKTX_STATS_EN
    logic [15:0] retrain_cnt_q, retrain_cnt_d;
    logic        train_entry;

    // An entry is any move into TRAIN, including a retrain that restarts an ongoing training.
    assign train_entry = (state_d == ST_TRAIN) & ((state_q != ST_TRAIN) | retrain);

    always_comb begin
        retrain_cnt_d = retrain_cnt_q;
        if (train_entry && (retrain_cnt_q != 16'hFFFF)) begin
            retrain_cnt_d = retrain_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retrain_cnt_q <= '0;
        end else begin
            retrain_cnt_q <= retrain_cnt_d;
        end
    end

    assign retrain_cnt = retrain_cnt_q;
`endif

endmodule

// File: tb/tb_tlk_tx_align.sv
// Self-checking bench for tlk_tx_align: bring-up timing, data path scoreboard, LIVE drop, retrain, async reset.
// Statistics scenario is compiled only when TLKTX_STATS_EN is defined.
module tb_tlk_tx_align;

    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          LIVE;
    logic          retrain;
    logic [DW-1:0] tx_data;
    logic          tx_en;
    logic          tx_er;
    logic          link_up;
`ifdef TLKTX_STATS_EN
    logic [15:0]   retrain_cnt;
`endif

    tlk_tx_align_if #(.DW(DW)) in_if ();

    tlk_tx_align #(
        .DW(DW), .TRAIN_CYCLES(1024), .HOLD_CYCLES(512), .TW(11)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .LIVE    (LIVE),
        .retrain (retrain),
        .in_if   (in_if.slave),
        .tx_data (tx_data),
        .tx_en   (tx_en),
        .tx_er   (tx_er),
        .link_up (link_up)
`ifdef TLKTX_STATS_EN
        ,
        .retrain_cnt (retrain_cnt)
`endif
    );

    int checks = 0;
    int passed = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge, away from the active edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; LIVE = 1'b0; retrain = 1'b0;
        in_if.in_valid = 1'b0; in_if.in_data = '0;
        #3;
        checks++;
        if ({tx_en, tx_er, link_up, tx_data} !== {3'b000, 16'h0000})
            $display("FAIL reset_outputs: got en=%b er=%b up=%b data=%h, required all 0", tx_en, tx_er, link_up, tx_data);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        step(); step();
        checks++;
        if ({tx_en, link_up, in_if.in_ready} !== 3'b000)
            $display("FAIL off_idle: got en=%b up=%b rdy=%b, required 000", tx_en, link_up, in_if.in_ready);
        else passed++;
    endtask

    // Called at the falling edge right after the edge that started training (cycle 1).
    task automatic check_sequence(input string tag);
        int train_bad = 0;
        int hold_bad = 0;
        for (int i = 1; i <= 1024; i++) begin
            if (!(tx_en === 1'b1 && tx_er === 1'b1 && tx_data === 16'hFFFF &&
                  link_up === 1'b0 && in_if.in_ready === 1'b0)) train_bad++;
            step();
        end
        for (int i = 1025; i <= 1536; i++) begin
            if (!(tx_en === 1'b0 && tx_er === 1'b0 && tx_data === 16'h0000 &&
                  link_up === 1'b0 && in_if.in_ready === 1'b0)) hold_bad++;
            step();
        end
        checks++;
        if (train_bad !== 0) $display("FAIL %s_train: got %0d bad cycles, required 0", tag, train_bad);
        else passed++;
        checks++;
        if (hold_bad !== 0) $display("FAIL %s_hold: got %0d bad cycles, required 0", tag, hold_bad);
        else passed++;
        checks++;
        if ({link_up, in_if.in_ready, tx_en} !== 3'b110)
            $display("FAIL %s_run_1537: got up=%b rdy=%b en=%b, required 110", tag, link_up, in_if.in_ready, tx_en);
        else passed++;
    endtask

    task automatic test_bringup();
        LIVE = 1'b1;
        step();
        check_sequence("bringup");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words[2];
        words[0] = 16'h1234;
        words[1] = 16'h5678;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                checks++;
                if (!(tx_en === 1'b1 && tx_er === 1'b0) || sb.size() == 0) begin
                    $display("FAIL b2b_data_%0d: got en=%b er=%b data=%h, required a DATA word", i, tx_en, tx_er, tx_data);
                end else begin
                    exp_w = sb.pop_front();
                    if (tx_data !== exp_w)
                        $display("FAIL b2b_word_%0d: got %h, required %h", i, tx_data, exp_w);
                    else begin
                        passed++;
                        $display("tx word %h", tx_data);
                    end
                end
            end
            if (i < 2) begin
                in_if.in_valid = 1'b1;
                in_if.in_data  = words[i];
                #1;
                checks++;
                if (in_if.in_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b, required 1", i, in_if.in_ready);
                else passed++;
                if (in_if.in_valid && in_if.in_ready) sb.push_back(in_if.in_data);
            end else begin
                in_if.in_valid = 1'b0;
                in_if.in_data  = 16'hAAAA;
            end
            step();
        end
        checks++;
        if ({tx_en, tx_er, tx_data} !== {2'b00, 16'h0000})
            $display("FAIL ignore_data: got en=%b er=%b data=%h, required IDLE", tx_en, tx_er, tx_data);
        else passed++;
        checks++;
        if (sb.size() !== 0) $display("FAIL sb_empty: got %0d pending, required 0", sb.size());
        else passed++;
    endtask

    task automatic test_live_drop();
        LIVE = 1'b0;
        in_if.in_valid = 1'b1;
        in_if.in_data  = 16'hDEAD;
        #1;
        checks++;
        if (in_if.in_ready !== 1'b0) $display("FAIL drop_ready: got %b, required 0", in_if.in_ready);
        else passed++;
        if (in_if.in_valid && in_if.in_ready) sb.push_back(in_if.in_data);
        step();
        in_if.in_valid = 1'b0;
        checks++;
        if ({tx_en, tx_er, link_up, tx_data} !== {3'b000, 16'h0000})
            $display("FAIL drop_idle: got en=%b er=%b up=%b data=%h, required all 0", tx_en, tx_er, link_up, tx_data);
        else passed++;
        LIVE = 1'b1;
        step();
        check_sequence("relive");
    endtask

    task automatic test_retrain();
        LIVE = 1'b0;
        step();
        LIVE = 1'b1;
        step();
        for (int i = 1; i < 1325; i++) step();
        checks++;
        if ({tx_en, tx_er, link_up} !== 3'b000)
            $display("FAIL settle_300: got en=%b er=%b up=%b, required 000", tx_en, tx_er, link_up);
        else passed++;
        retrain = 1'b1;
        step();
        retrain = 1'b0;
        check_sequence("retrain");
    endtask

    task automatic test_async_reset();
        LIVE = 1'b0;
        step();
        LIVE = 1'b1;
        step(); step(); step();
        checks++;
        if ({tx_en, tx_er} !== 2'b11) $display("FAIL pre_reset_train: got en=%b er=%b, required 11", tx_en, tx_er);
        else passed++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({tx_en, tx_er, tx_data} !== {2'b00, 16'h0000})
            $display("FAIL async_reset: got en=%b er=%b data=%h, required 0", tx_en, tx_er, tx_data);
        else passed++;
        LIVE = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(); step();
        checks++;
        if ({tx_en, link_up} !== 2'b00) $display("FAIL post_reset_off: got en=%b up=%b, required 00", tx_en, link_up);
        else passed++;
        LIVE = 1'b1;
        step();
        checks++;
        if ({tx_en, tx_er} !== 2'b11) $display("FAIL post_reset_train: got en=%b er=%b, required 11", tx_en, tx_er);
        else passed++;
    endtask

`ifdef TLKTX_STATS_EN
    task automatic test_stats();
        LIVE = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (retrain_cnt !== 16'h0000) $display("FAIL stats_reset: got %h, required 0000", retrain_cnt);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        LIVE = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            retrain = 1'b1;
            step();
            retrain = 1'b0;
            step();
        end
        checks++;
        if (retrain_cnt !== 16'd4) $display("FAIL stats_count: got %0d, required 4", retrain_cnt);
        else passed++;
        retrain = 1'b1;
        for (int i = 0; i < 65540; i++) @(negedge clk);
        retrain = 1'b0;
        step();
        checks++;
        if (retrain_cnt !== 16'hFFFF) $display("FAIL stats_saturate: got %h, required FFFF", retrain_cnt);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_bringup();
        test_back_to_back();
        test_live_drop();
        test_retrain();
        test_async_reset();
`ifdef TLKTX_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
